msiq_cam_multi: RTL and testbench

- Parametrised miss/store-in-queue address CAM.
- Holds up to DEPTH outstanding line addresses and probes them in parallel from NCHK load/store check ports, including split (even+odd bank) accesses.
- Over the 8x4 fixed queue it adds:
  - duplicate-write merge with index return;
  - per-entry release by index;
  - an occupancy counter and an almost-full flag.
- Sits beside the LSQ miss path; the LSQ stalls probes that hit.

---
 rtl/msiq_cam_multi.sv | 115 +++++++++++
 tb/tb_msiq_cam_multi.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/msiq_cam_multi.sv
// Miss/store-in-queue line-address CAM: parallel multi-port probe (incl. split
// even/odd bank accesses), merging insert with index return, release by index, occupancy.
module msiq_cam_multi #(
  parameter int DEPTH  = 8,
  parameter int NCHK   = 4,
  parameter int ADDR_W = 37,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int AFULL  = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       all_clear,
  input  logic [NCHK*(ADDR_W-1)-1:0] chk_addrE,
  input  logic [NCHK*(ADDR_W-1)-1:0] chk_addrO,
  input  logic [NCHK-1:0]            chk_odd,
  input  logic [NCHK-1:0]            chk_split,
  input  logic [NCHK-1:0]            chk_en,
  output logic [NCHK-1:0]            chk_hit,
  output logic [NCHK*IDX_W-1:0]      chk_hit_idx,
  input  logic [ADDR_W-1:0]          wrt_addr,
  input  logic                       wrt_en,
  output logic                       wrt_ack,
  output logic                       wrt_dup,
  output logic [IDX_W-1:0]           wrt_idx,
  output logic                       wrt_can,
  output logic                       wrt_afull,
  input  logic                       rel_en,
  input  logic [IDX_W-1:0]           rel_idx,
  output logic [IDX_W:0]             occ
);

  typedef enum logic {FREE = 1'b0, BUSY = 1'b1} ent_st_t;

  ent_st_t           st   [DEPTH];
  logic [ADDR_W-1:0] addr [DEPTH];

  logic             dup, has_free, wr_go, alloc, rel_eff;
  logic [IDX_W-1:0] dup_idx, free_idx;

  // Probe: the line-address tag (bits above bank parity) is compared against the
  // even or odd port address depending on which bank the entry lives in.
  always_comb begin
    chk_hit     = '0;
    chk_hit_idx = '0;
    for (int unsigned k = 0; k < NCHK; k++) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        if (!chk_hit[k] && chk_en[k] && st[e] == BUSY &&
            ((!addr[e][0] && (!chk_odd[k] || chk_split[k]) &&
              chk_addrE[k*(ADDR_W-1) +: ADDR_W-1] == addr[e][ADDR_W-1:1]) ||
             ( addr[e][0] && ( chk_odd[k] || chk_split[k]) &&
              chk_addrO[k*(ADDR_W-1) +: ADDR_W-1] == addr[e][ADDR_W-1:1]))) begin
          chk_hit[k]                   = 1'b1;
          chk_hit_idx[k*IDX_W +: IDX_W] = IDX_W'(e);
        end
      end
    end
  end

  always_comb begin
    dup      = 1'b0;
    dup_idx  = '0;
    has_free = 1'b0;
    free_idx = '0;
    for (int unsigned e = 0; e < DEPTH; e++) begin
      if (!dup && st[e] == BUSY && addr[e] == wrt_addr) begin
        dup     = 1'b1;
        dup_idx = IDX_W'(e);
      end
      if (!has_free && st[e] == FREE) begin
        has_free = 1'b1;
        free_idx = IDX_W'(e);
      end
    end
  end

  always_comb begin
    wr_go   = wrt_en && !all_clear;
    alloc   = wr_go && !dup && has_free;
    rel_eff = rel_en && !all_clear && st[rel_idx] == BUSY;
    wrt_dup = wr_go && dup;
    wrt_ack = wr_go && (dup || has_free);
    wrt_idx = '0;
    if (wr_go && dup)
      wrt_idx = dup_idx;
    else if (alloc)
      wrt_idx = free_idx;
    wrt_can   = has_free;
    wrt_afull = occ >= (IDX_W+1)'(AFULL);
  end

  // Allocation picks from pre-edge FREE entries, so a slot released this cycle
  // (still BUSY) can never be handed out in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        st[e]   <= FREE;
        addr[e] <= '0;
      end
      occ <= '0;
    end else if (all_clear) begin
      for (int unsigned e = 0; e < DEPTH; e++)
        st[e] <= FREE;
      occ <= '0;
    end else begin
      if (rel_eff)
        st[rel_idx] <= FREE;
      if (alloc) begin
        st[free_idx]   <= BUSY;
        addr[free_idx] <= wrt_addr;
      end
      occ <= occ + (IDX_W+1)'(alloc) - (IDX_W+1)'(rel_eff);
    end
  end

endmodule

// File: tb/tb_msiq_cam_multi.sv
// Directed bench for msiq_cam_multi at default parameters (DEPTH=8, NCHK=4, ADDR_W=37).
module tb_msiq_cam_multi;

  localparam int DEPTH = 8;
  localparam int NCHK  = 4;
  localparam int AW    = 37;
  localparam int TW    = AW - 1;
  localparam int IW    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               all_clear;
  logic [NCHK*TW-1:0] chk_addrE, chk_addrO;
  logic [NCHK-1:0]    chk_odd, chk_split, chk_en, chk_hit;
  logic [NCHK*IW-1:0] chk_hit_idx;
  logic [AW-1:0]      wrt_addr;
  logic               wrt_en, wrt_ack, wrt_dup, wrt_can, wrt_afull, rel_en;
  logic [IW-1:0]      wrt_idx, rel_idx;
  logic [IW:0]        occ;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msiq_cam_multi #(.DEPTH(DEPTH), .NCHK(NCHK), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .all_clear(all_clear),
    .chk_addrE(chk_addrE), .chk_addrO(chk_addrO), .chk_odd(chk_odd),
    .chk_split(chk_split), .chk_en(chk_en), .chk_hit(chk_hit),
    .chk_hit_idx(chk_hit_idx), .wrt_addr(wrt_addr), .wrt_en(wrt_en),
    .wrt_ack(wrt_ack), .wrt_dup(wrt_dup), .wrt_idx(wrt_idx),
    .wrt_can(wrt_can), .wrt_afull(wrt_afull), .rel_en(rel_en),
    .rel_idx(rel_idx), .occ(occ)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probes_off();
    chk_addrE = '0; chk_addrO = '0;
    chk_odd = '0; chk_split = '0; chk_en = '0;
  endtask

  task automatic probe(input int k, input logic [TW-1:0] e, input logic [TW-1:0] o,
                       input logic odd, input logic split);
    chk_addrE[k*TW +: TW] = e;
    chk_addrO[k*TW +: TW] = o;
    chk_odd[k]   = odd;
    chk_split[k] = split;
    chk_en[k]    = 1'b1;
  endtask

  initial begin
    rst = 1'b0; all_clear = 1'b0; wrt_en = 1'b0; wrt_addr = '0;
    rel_en = 1'b0; rel_idx = '0;
    probes_off();
    #3;
    check("rst_occ", occ, 0);
    check("rst_can", wrt_can, 1);
    check("rst_afull", wrt_afull, 0);
    check("rst_ack", wrt_ack, 0);
    probe(0, 36'h8, 36'h8, 1'b0, 1'b1);
    #1;
    check("rst_hit", chk_hit, 0);
    probes_off();
    rst = 1'b1;
    tick();

    // first allocation, then even probe
    wrt_en = 1'b1; wrt_addr = 37'h10; #1;
    check("w0_ack", wrt_ack, 1);
    check("w0_dup", wrt_dup, 0);
    check("w0_idx", wrt_idx, 0);
    probe(0, 36'h8, 36'h0, 1'b0, 1'b0); #1;
    check("w0_not_yet_visible", chk_hit, 0);
    tick(); wrt_en = 1'b0; #1;
    check("w0_occ", occ, 1);
    check("w0_hit", chk_hit, 4'b0001);
    check("w0_hit_idx", chk_hit_idx, 0);
    probes_off();

    // duplicate merge
    wrt_en = 1'b1; wrt_addr = 37'h10; #1;
    check("dup_flag", wrt_dup, 1);
    check("dup_ack", wrt_ack, 1);
    check("dup_idx", wrt_idx, 0);
    tick(); wrt_en = 1'b0; #1;
    check("dup_occ", occ, 1);

    wrt_en = 1'b1; wrt_addr = 37'h11; #1;
    check("w1_idx", wrt_idx, 1);
    check("w1_dup", wrt_dup, 0);
    tick(); wrt_en = 1'b0; #1;
    check("w1_occ", occ, 2);

    // port1 split -> idx0, port2 odd -> idx1, port3 even miss
    probe(1, 36'h8, 36'h8, 1'b0, 1'b1);
    probe(2, 36'h0, 36'h8, 1'b1, 1'b0);
    probe(3, 36'h9, 36'h8, 1'b0, 1'b0);
    #1;
    check("mp_hit", chk_hit, 4'b0110);
    check("mp_idx", chk_hit_idx, 12'h040);
    probes_off();

    // fill to full: 0x20..0x25 land at idx 2..7
    for (int i = 0; i < 6; i++) begin
      wrt_en = 1'b1; wrt_addr = 37'h20 + 37'(i); #1;
      check("fill_idx", wrt_idx, 64'(i + 2));
      tick(); wrt_en = 1'b0; #1;
      check("fill_occ", occ, 64'(i + 3));
      check("fill_afull", wrt_afull, (i + 3 >= 6) ? 1 : 0);
      check("fill_can", wrt_can, (i + 3 < 8) ? 1 : 0);
    end

    wrt_en = 1'b1; wrt_addr = 37'h30; #1;
    check("full_ack", wrt_ack, 0);
    check("full_idx", wrt_idx, 0);
    check("full_dup", wrt_dup, 0);
    wrt_addr = 37'h22; #1;
    check("full_merge_ack", wrt_ack, 1);
    check("full_merge_idx", wrt_idx, 4);
    wrt_addr = 37'h30;
    tick(); wrt_en = 1'b0; #1;
    check("full_occ", occ, 8);

    // release idx3 with a write in the same cycle: slot not reused yet
    rel_en = 1'b1; rel_idx = 3; wrt_en = 1'b1; wrt_addr = 37'h30; #1;
    check("relw_ack", wrt_ack, 0);
    tick(); rel_en = 1'b0; #1;
    check("relw_occ", occ, 7);
    check("relw_can", wrt_can, 1);
    check("relw2_ack", wrt_ack, 1);
    check("relw2_idx", wrt_idx, 3);
    tick(); wrt_en = 1'b0; #1;
    check("relw2_occ", occ, 8);

    // released entry still hits in its release cycle, misses after
    rel_en = 1'b1; rel_idx = 7;
    probe(0, 36'h0, 36'h12, 1'b1, 1'b0); #1;
    check("rel_same_hit", chk_hit, 4'b0001);
    check("rel_same_idx", chk_hit_idx, 7);
    tick(); rel_en = 1'b0; #1;
    check("rel_after_hit", chk_hit, 0);
    check("rel_occ", occ, 7);
    probes_off();

    rel_en = 1'b1; rel_idx = 7;
    tick(); rel_en = 1'b0; #1;
    check("rel_free_occ", occ, 7);

    // write merges into an entry being released: reported as dup, entry freed
    rel_en = 1'b1; rel_idx = 6; wrt_en = 1'b1; wrt_addr = 37'h24; #1;
    check("relmerge_dup", wrt_dup, 1);
    check("relmerge_idx", wrt_idx, 6);
    tick(); rel_en = 1'b0; wrt_en = 1'b0;
    probe(0, 36'h12, 36'h0, 1'b0, 1'b0); #1;
    check("relmerge_occ", occ, 6);
    check("relmerge_gone", chk_hit, 0);
    probes_off();

    // all_clear beats write and release; probes see pre-clear state
    all_clear = 1'b1; wrt_en = 1'b1; wrt_addr = 37'h50; rel_en = 1'b1; rel_idx = 0;
    probe(0, 36'h8, 36'h0, 1'b0, 1'b0); #1;
    check("clr_ack", wrt_ack, 0);
    check("clr_dup", wrt_dup, 0);
    check("clr_prehit", chk_hit, 4'b0001);
    tick(); all_clear = 1'b0; wrt_en = 1'b0; rel_en = 1'b0;
    probe(1, 36'h8, 36'h8, 1'b0, 1'b1);
    probe(2, 36'h28, 36'h28, 1'b0, 1'b1); #1;
    check("clr_occ", occ, 0);
    check("clr_can", wrt_can, 1);
    check("clr_afull", wrt_afull, 0);
    check("clr_hit", chk_hit, 0);
    probes_off();

    // asynchronous reset with 5 valid entries
    for (int i = 0; i < 5; i++) begin
      wrt_en = 1'b1; wrt_addr = 37'h60 + 37'(i);
      tick();
    end
    wrt_en = 1'b0;
    probe(0, 36'h30, 36'h0, 1'b0, 1'b0); #1;
    check("pre_arst_occ", occ, 5);
    check("pre_arst_hit", chk_hit, 4'b0001);
    #1 rst = 1'b0;
    #1;
    check("arst_occ", occ, 0);
    check("arst_hit", chk_hit, 0);
    check("arst_can", wrt_can, 1);
    rst = 1'b1;
    probes_off();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
